alu_rr_arbiter: RTL

//   Shares one combinational alu (A,B,ALUOp -> C) between two requesters.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_rr_arbiter_if.sv | 37 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_rr_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared widths, requester-id type and ALUOp encodings for the round-robin alu front end.
package alu_arb_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 3;
    localparam int unsigned IDW   = 1;

    typedef logic [IDW-1:0] req_id_t;

    // The front end never decodes the op; these are for the external alu and the bench.
    typedef enum logic [OPW-1:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4
    } alu_op_e;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of the two request ports, the alu operand/result wires and the response port.
interface alu_rr_arbiter_if;

    logic [1:0]                          req_valid;
    logic [1:0]                          req_ready;
    logic [alu_arb_pkg::WIDTH-1:0]       req_a0;
    logic [alu_arb_pkg::WIDTH-1:0]       req_b0;
    logic [alu_arb_pkg::OPW-1:0]         req_op0;
    logic [alu_arb_pkg::WIDTH-1:0]       req_a1;
    logic [alu_arb_pkg::WIDTH-1:0]       req_b1;
    logic [alu_arb_pkg::OPW-1:0]         req_op1;

    logic [alu_arb_pkg::WIDTH-1:0]       alu_a;
    logic [alu_arb_pkg::WIDTH-1:0]       alu_b;
    logic [alu_arb_pkg::OPW-1:0]         alu_op;
    logic [alu_arb_pkg::WIDTH-1:0]       alu_c;

    logic                                rsp_valid;
    alu_arb_pkg::req_id_t                rsp_id;
    logic [alu_arb_pkg::WIDTH-1:0]       rsp_data;
    logic                                rsp_ready;

    // Arbiter side
    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
    );

    // Requesters / alu / consumer side
    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted requester across handshakes.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant_id,
    output logic       any
);

    logic last_grant_q;

    // Pick the sole requester, or the one not served last time on a tie
    always_comb begin
        any      = |valid;
        grant_id = 1'b0;
        unique case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant_q;
            default: grant_id = 1'b0;
        endcase
    end

    // Priority only rotates on an accepted request, so stalls never skip a requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (advance) begin
            last_grant_q <= grant_id;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational alu between two requesters.
// Issue register drives the alu; result register captures C with the owner's id.
module alu_rr_arbiter import alu_arb_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    alu_rr_arbiter_if.slave    bus
);

    logic             iss_valid_q;
    req_id_t          iss_id_q;
    logic [WIDTH-1:0] iss_a_q;
    logic [WIDTH-1:0] iss_b_q;
    logic [OPW-1:0]   iss_op_q;

    logic             rsp_valid_q;
    req_id_t          rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic rsp_free;
    logic iss_adv;
    logic iss_free;
    logic req_hs;
    logic grant_id;
    logic any;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.req_valid),
        .advance  (req_hs),
        .grant_id (grant_id),
        .any      (any)
    );

    // Pipeline flow control and the one-hot request accept
    always_comb begin
        rsp_free      = !rsp_valid_q || bus.rsp_ready;
        iss_adv       = iss_valid_q && rsp_free;
        iss_free      = !iss_valid_q || iss_adv;
        req_hs        = iss_free && any;
        bus.req_ready = {req_hs && grant_id, req_hs && !grant_id};
    end

    // Issue stage: operands only change on an accept, so alu inputs hold while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_op_q    <= '0;
        end else if (req_hs) begin
            iss_valid_q <= 1'b1;
            iss_id_q    <= req_id_t'(grant_id);
            iss_a_q     <= grant_id ? bus.req_a1  : bus.req_a0;
            iss_b_q     <= grant_id ? bus.req_b1  : bus.req_b0;
            iss_op_q    <= grant_id ? bus.req_op1 : bus.req_op0;
        end else if (iss_adv) begin
            iss_valid_q <= 1'b0;
        end
    end

    // Result stage: capture alu C on advance, clear once consumed with nothing behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else if (iss_adv) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= iss_id_q;
            rsp_data_q  <= bus.alu_c;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Register outputs straight to the bus
    always_comb begin
        bus.alu_a     = iss_a_q;
        bus.alu_b     = iss_b_q;
        bus.alu_op    = iss_op_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_id    = rsp_id_q;
        bus.rsp_data  = rsp_data_q;
    end

endmodule
